// File: rtl/display_regfile_pkg.sv
// Shared definitions for the display register file: register index map,
// COMMIT address helper and default staleness window.
package display_regfile_pkg;

    // Register indices used by the display rendering logic
    localparam int REG_SPEED     = 0;
    localparam int REG_READY     = 1;
    localparam int REG_CAR_BATT  = 2;
    localparam int REG_DISP_BATT = 3;
    localparam int REG_GPS       = 4;
    localparam int REG_ERR       = 5;

    // Ticks without a refresh before a register is flagged stale
    localparam int DEFAULT_STALE_TICKS = 250;

    // The COMMIT address is the all-ones value of the address bus
    function automatic int unsigned commit_addr(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

endpackage

// File: rtl/display_regfile_stale_timer.sv
// Per-register staleness timer. Counts ticks since the last refresh and
// saturates at STALE_TICKS; the register is stale while saturated.
// After reset the timer starts saturated because no data has arrived yet.
module stale_timer
    import display_regfile_pkg::*;
#(
    parameter int STALE_TICKS = DEFAULT_STALE_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic clear,
    output logic stale
);

    localparam int CW = (STALE_TICKS < 2) ? 1 : $clog2(STALE_TICKS + 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(STALE_TICKS);

    logic [CW-1:0] count;

    // Refresh clears the count and takes priority over a coincident tick
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= MAX_COUNT;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != MAX_COUNT)) begin
            count <= count + 1'b1;
        end
    end

    assign stale = (count == MAX_COUNT);

endmodule

// File: rtl/display_regfile.sv
// Display register file: host writes go to a shadow bank and are copied to
// the live bank atomically by a write to the COMMIT address (all ones), so
// the renderer never sees half-updated state. Provides registered readback
// of the shadow bank, an unmapped-address error pulse and, when the macro
// DISPLAY_REGFILE_STALE_EN is defined, per-register staleness flags.
module display_regfile
    import display_regfile_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int STALE_TICKS = DEFAULT_STALE_TICKS,
    parameter int AUTO_COMMIT = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       write,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          data_in,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic [NUM_REGS-1:0]        stale,
    output logic                       commit_pulse,
    output logic                       addr_err
);

    localparam logic [ADDR_W-1:0] COMMIT_ADDR = ADDR_W'(commit_addr(ADDR_W));
    localparam logic [ADDR_W-1:0] REG_LIMIT   = ADDR_W'(NUM_REGS);

    logic [DATA_W-1:0]   shadow [NUM_REGS];
    logic [DATA_W-1:0]   live   [NUM_REGS];
    logic [NUM_REGS-1:0] wr_sel;
    logic                wr_reg;
    logic                wr_commit;
    logic                wr_unmapped;
    logic [DATA_W-1:0]   rd_next;

    // Decode the host write into register select, commit or unmapped error
    always_comb begin
        wr_reg      = write && (addr < REG_LIMIT);
        wr_commit   = write && (addr == COMMIT_ADDR);
        wr_unmapped = write && !wr_reg && !wr_commit;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = write && (addr == ADDR_W'(i));
        end
    end

    // Shadow bank takes every mapped host write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) shadow[i] <= data_in;
            end
        end
    end

    // Live bank copies the whole shadow on COMMIT, or tracks writes directly in auto-commit builds
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) live[i] <= '0;
        end else if (wr_commit) begin
            for (int i = 0; i < NUM_REGS; i++) live[i] <= shadow[i];
        end else if (AUTO_COMMIT != 0) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) live[i] <= data_in;
            end
        end
    end

    // Readback mux forwards a same-edge write so rd_data always shows the post-write shadow
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_next = wr_sel[i] ? data_in : shadow[i];
        end
    end

    // Registered readback and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data      <= '0;
            commit_pulse <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            rd_data      <= rd_next;
            commit_pulse <= wr_commit;
            addr_err     <= wr_unmapped;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_out
            assign regs_out[g*DATA_W +: DATA_W] = live[g];
        end
    endgenerate

`ifdef DISPLAY_REGFILE_STALE_EN
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_stale
            stale_timer #(
                .STALE_TICKS(STALE_TICKS)
            ) u_stale_timer (
                .clk  (clk),
                .reset(reset),
                .tick (tick),
                .clear(wr_sel[g]),
                .stale(stale[g])
            );
        end
    endgenerate
`else
    logic unused_tick;
    assign unused_tick = tick;
    assign stale       = '0;
`endif

endmodule

// File: tb/tb_display_regfile.sv
// Testbench for display_regfile. Two instances share one stimulus stream:
// instance A (6 registers, explicit commit) and instance B (8 registers,
// auto-commit), both with a 3-tick staleness window. A behavioural model
// tracks each instance and is compared against the outputs every cycle;
// directed literal checks pin the model to hand-computed values.
module tb_display_regfile;

`ifdef DISPLAY_REGFILE_STALE_EN
    localparam bit STALE_ON = 1'b1;
`else
    localparam bit STALE_ON = 1'b0;
`endif

    localparam int STALE_N = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  addr = '0;
    logic [7:0]  data_in = '0;
    logic [3:0]  rd_addr = '0;

    logic [7:0]  a_rd_data, b_rd_data;
    logic [47:0] a_regs_out;
    logic [63:0] b_regs_out;
    logic [5:0]  a_stale;
    logic [7:0]  b_stale;
    logic        a_commit, b_commit, a_err, b_err;

    int total = 0;
    int bad   = 0;

    display_regfile #(
        .NUM_REGS(6), .DATA_W(8), .ADDR_W(4), .STALE_TICKS(STALE_N), .AUTO_COMMIT(0)
    ) u_dut_a (
        .clk(clk), .reset(reset), .tick(tick), .write(write), .addr(addr),
        .data_in(data_in), .rd_addr(rd_addr), .rd_data(a_rd_data),
        .regs_out(a_regs_out), .stale(a_stale), .commit_pulse(a_commit),
        .addr_err(a_err)
    );

    display_regfile #(
        .NUM_REGS(8), .DATA_W(8), .ADDR_W(4), .STALE_TICKS(STALE_N), .AUTO_COMMIT(1)
    ) u_dut_b (
        .clk(clk), .reset(reset), .tick(tick), .write(write), .addr(addr),
        .data_in(data_in), .rd_addr(rd_addr), .rd_data(b_rd_data),
        .regs_out(b_regs_out), .stale(b_stale), .commit_pulse(b_commit),
        .addr_err(b_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: index 0 = instance A, index 1 = instance B
    int         m_nregs [2] = '{6, 8};
    bit         m_auto  [2] = '{1'b0, 1'b1};
    logic [7:0] m_shadow [2][8];
    logic [7:0] m_live   [2][8];
    int         m_cnt    [2][8];
    logic [7:0] m_rd     [2];
    bit         m_commit [2];
    bit         m_err    [2];
    bit         model_ok = 1'b0;

    task automatic modelStep(input int k);
        int a;
        a = int'(addr);
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                m_shadow[k][i] = 8'h00;
                m_live[k][i]   = 8'h00;
                m_cnt[k][i]    = STALE_N;
            end
            m_rd[k] = 8'h00; m_commit[k] = 1'b0; m_err[k] = 1'b0;
            return;
        end
        m_commit[k] = 1'b0;
        m_err[k]    = 1'b0;
        for (int i = 0; i < m_nregs[k]; i++) begin
            if (write && a == i) m_cnt[k][i] = 0;
            else if (tick && m_cnt[k][i] < STALE_N) m_cnt[k][i] = m_cnt[k][i] + 1;
        end
        if (write) begin
            if (a < m_nregs[k]) begin
                m_shadow[k][a] = data_in;
                if (m_auto[k]) m_live[k][a] = data_in;
            end else if (a == 15) begin
                for (int i = 0; i < 8; i++) m_live[k][i] = m_shadow[k][i];
                m_commit[k] = 1'b1;
            end else begin
                m_err[k] = 1'b1;
            end
        end
        m_rd[k] = (int'(rd_addr) < m_nregs[k]) ? m_shadow[k][rd_addr[2:0]] : 8'h00;
    endtask

    // Advance the model on each active edge from the same sampled inputs
    always @(posedge clk) begin
        modelStep(0);
        modelStep(1);
        if (reset) model_ok = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (model_ok) begin
            logic [47:0] ea;
            logic [63:0] eb;
            logic [5:0]  sa;
            logic [7:0]  sb;
            for (int i = 0; i < 6; i++) begin
                ea[i*8 +: 8] = m_live[0][i];
                sa[i] = STALE_ON && (m_cnt[0][i] == STALE_N);
            end
            for (int i = 0; i < 8; i++) begin
                eb[i*8 +: 8] = m_live[1][i];
                sb[i] = STALE_ON && (m_cnt[1][i] == STALE_N);
            end
            checkOutput("a_regs_out", 64'(a_regs_out), 64'(ea));
            checkOutput("b_regs_out", b_regs_out, eb);
            checkOutput("a_rd_data", 64'(a_rd_data), 64'(m_rd[0]));
            checkOutput("b_rd_data", 64'(b_rd_data), 64'(m_rd[1]));
            checkOutput("a_stale", 64'(a_stale), 64'(sa));
            checkOutput("b_stale", 64'(b_stale), 64'(sb));
            checkOutput("a_commit", 64'(a_commit), 64'(m_commit[0]));
            checkOutput("b_commit", 64'(b_commit), 64'(m_commit[1]));
            checkOutput("a_err", 64'(a_err), 64'(m_err[0]));
            checkOutput("b_err", 64'(b_err), 64'(m_err[1]));
        end
    end

    // Drive one cycle of inputs away from the edge, then settle after the edge
    task automatic applyStimulus(input bit rst, input bit wr, input logic [3:0] a,
                                 input logic [7:0] d, input bit tk, input logic [3:0] ra);
        @(negedge clk);
        reset   = rst;
        write   = wr;
        addr    = a;
        data_in = d;
        tick    = tk;
        rd_addr = ra;
        @(posedge clk);
        #2;
    endtask

    initial begin
        $display("[TB] display_regfile bench start, stale feature=%0d", STALE_ON);

        // Reset, with a write on the last reset cycle that must be discarded
        applyStimulus(1, 0, 4'h0, 8'h00, 0, 4'h0);
        applyStimulus(1, 1, 4'h0, 8'hEE, 0, 4'h0);
        checkOutput("rst_a_regs", 64'(a_regs_out), 64'h0);
        checkOutput("rst_b_regs", b_regs_out, 64'h0);
        checkOutput("rst_a_rd", 64'(a_rd_data), 64'h0);
        checkOutput("rst_a_stale", 64'(a_stale), STALE_ON ? 64'h3F : 64'h0);
        checkOutput("rst_b_stale", 64'(b_stale), STALE_ON ? 64'hFF : 64'h0);

        applyStimulus(0, 0, 4'h0, 8'h00, 0, 4'h0);

        // Shadow write is readable but not live without a commit
        applyStimulus(0, 1, 4'h0, 8'h2A, 0, 4'h0);
        checkOutput("w0_a_rd", 64'(a_rd_data), 64'h2A);
        checkOutput("w0_a_live0", 64'(a_regs_out[7:0]), 64'h0);
        checkOutput("w0_b_live0", 64'(b_regs_out[7:0]), 64'h2A);
        checkOutput("w0_a_stale", 64'(a_stale), STALE_ON ? 64'h3E : 64'h0);
        applyStimulus(0, 0, 4'h0, 8'h00, 0, 4'h0);
        checkOutput("w0_a_rd_hold", 64'(a_rd_data), 64'h2A);

        // Second write then COMMIT: both land on the same edge
        applyStimulus(0, 1, 4'h2, 8'h55, 0, 4'h2);
        checkOutput("w2_a_rd", 64'(a_rd_data), 64'h55);
        checkOutput("w2_a_regs_pre", 64'(a_regs_out), 64'h0);
        applyStimulus(0, 1, 4'hF, 8'hFF, 0, 4'h2);
        checkOutput("cm_a_regs", 64'(a_regs_out), 64'h0000_0055_002A);
        checkOutput("cm_a_pulse", 64'(a_commit), 64'h1);
        checkOutput("cm_a_err", 64'(a_err), 64'h0);
        checkOutput("cm_a_stale", 64'(a_stale), STALE_ON ? 64'h3A : 64'h0);
        applyStimulus(0, 0, 4'h0, 8'h00, 0, 4'h2);
        checkOutput("cm_a_pulse_end", 64'(a_commit), 64'h0);

        // Staleness: refresh reg 1, then three ticks saturate it
        applyStimulus(0, 1, 4'h1, 8'h11, 0, 4'h1);
        checkOutput("st_w1", 64'(a_stale), STALE_ON ? 64'h38 : 64'h0);
        applyStimulus(0, 0, 4'h0, 8'h00, 1, 4'h1);
        applyStimulus(0, 0, 4'h0, 8'h00, 1, 4'h1);
        checkOutput("st_tick2", 64'(a_stale[1]), 64'h0);
        applyStimulus(0, 0, 4'h0, 8'h00, 1, 4'h1);
        checkOutput("st_tick3", 64'(a_stale[1]), STALE_ON ? 64'h1 : 64'h0);
        applyStimulus(0, 1, 4'h1, 8'h22, 1, 4'h1);
        checkOutput("st_tick_wr", 64'(a_stale), STALE_ON ? 64'h3D : 64'h0);

        // Unmapped address on A (and B), then addr 6 is unmapped only on A
        applyStimulus(0, 1, 4'h9, 8'hAB, 0, 4'h6);
        checkOutput("ae9_a_err", 64'(a_err), 64'h1);
        checkOutput("ae9_b_err", 64'(b_err), 64'h1);
        checkOutput("ae9_a_regs", 64'(a_regs_out), 64'h0000_0055_002A);
        applyStimulus(0, 1, 4'h6, 8'h66, 0, 4'h6);
        checkOutput("ae6_a_err", 64'(a_err), 64'h1);
        checkOutput("ae6_b_err", 64'(b_err), 64'h0);
        checkOutput("ae6_a_rd", 64'(a_rd_data), 64'h0);
        checkOutput("ae6_b_rd", 64'(b_rd_data), 64'h66);
        applyStimulus(0, 1, 4'hF, 8'h00, 0, 4'h1);
        checkOutput("cm2_a_err", 64'(a_err), 64'h0);
        checkOutput("cm2_a_pulse", 64'(a_commit), 64'h1);
        checkOutput("cm2_a_regs", 64'(a_regs_out), 64'h0000_0055_222A);

        // Auto-commit instance shows a write on the same edge
        applyStimulus(0, 1, 4'h3, 8'h99, 0, 4'h3);
        checkOutput("ac_b_reg3", 64'(b_regs_out[31:24]), 64'h99);
        checkOutput("ac_a_reg3", 64'(a_regs_out[31:24]), 64'h0);

        // Back-to-back writes with interleaved ticks and a sweeping read address
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, 1, 4'(k % 8), 8'(k * 17 + 3), (k % 3) == 0, 4'((k + 5) % 8));
        end
        applyStimulus(0, 1, 4'hF, 8'h00, 1, 4'h0);
        applyStimulus(0, 0, 4'h0, 8'h00, 0, 4'h7);

        // Reset asserted together with a write: the write is lost
        applyStimulus(1, 1, 4'h3, 8'h77, 0, 4'h3);
        checkOutput("rw_a_regs", 64'(a_regs_out), 64'h0);
        checkOutput("rw_b_regs", b_regs_out, 64'h0);
        checkOutput("rw_b_rd", 64'(b_rd_data), 64'h0);
        applyStimulus(0, 0, 4'h0, 8'h00, 0, 4'h3);
        applyStimulus(0, 0, 4'h0, 8'h00, 0, 4'h3);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
